pipe_stage_reg_chain: RTL and testbench

Parametrised successor to the single-stage ID/EXE pipeline register. It is a DEPTH-deep chain of {valid, control, data} pipeline registers with a global enable (freeze), a stage-0 flush that inserts a bubble, a full-chain flush, and per-stage output taps. It drops in between any two pipeline stages, or spans several when DEPTH>1. It also provides a registered occupancy count and a saturating bubble counter for hazard/branch profiling.

---
 rtl/pipe_stage_reg_chain.sv | 136 +++++++++++++
 tb/tb_pipe_stage_reg_chain.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg_chain.sv
// pipe_stage_reg_chain
// DEPTH-deep chain of {valid, ctrl, data} pipeline registers. Generalises the
// single-stage ID/EXE register: DEPTH=1 gives the same one-cycle behaviour.
//
// Valid semantics: there is no ready/backpressure. in_valid qualifies in_ctrl
// and in_data on every edge on which the chain advances. out_valid qualifies
// out_ctrl/out_data. freeze is the only stall, and while it is held nothing
// moves. flush and flush_all take priority over freeze. Control is always
// gated by valid, so an invalid stage never carries a nonzero control word.
//
// Per-edge priority: rst > flush_all > flush > freeze > normal advance.
//
// Side outputs: occupancy is a registered popcount of the stage valids after
// the same edge. bubble_cnt saturates at all-ones and is cleared only by rst.

module pipe_stage_reg_chain #(
   parameter int CTRL_W     = 8,
   parameter int DATA_W     = 128,
   parameter int DEPTH      = 1,   // legal range 1..8
   parameter int CLEAR_DATA = 1,   // 1: flushes also zero the data field
   parameter int BUB_CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 freeze,
   input  logic                 flush,
   input  logic                 flush_all,
   input  logic                 in_valid,
   input  logic [CTRL_W-1:0]    in_ctrl,
   input  logic [DATA_W-1:0]    in_data,
   output logic                 out_valid,
   output logic [CTRL_W-1:0]    out_ctrl,
   output logic [DATA_W-1:0]    out_data,
   output logic [DEPTH-1:0]     tap_valid,
   output logic [3:0]           occupancy,
   output logic [BUB_CNT_W-1:0] bubble_cnt
);

   // Stage registers; index 0 is the entry stage and DEPTH-1 drives out_*.
   logic [DEPTH-1:0]  valid_q;
   logic [CTRL_W-1:0] ctrl_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   // Next-state values for the stage registers.
   logic [DEPTH-1:0]  valid_d;
   logic [CTRL_W-1:0] ctrl_d [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];

   // Bookkeeping.
   logic                 bubble_ev;   // stage 0 takes a bubble on this edge
   logic [3:0]           occ_d;
   logic [3:0]           occ_q;
   logic [BUB_CNT_W-1:0] bub_q;

   localparam logic [BUB_CNT_W-1:0] BUB_ONE = {{(BUB_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [BUB_CNT_W-1:0] BUB_MAX = {BUB_CNT_W{1'b1}};

   // Next state of the chain in priority order flush_all > flush > freeze > advance.
   always_comb begin
      valid_d   = valid_q;
      ctrl_d    = ctrl_q;
      data_d    = data_q;
      bubble_ev = 1'b0;

      if (flush_all) begin
         // Invalidate everything; data is optionally retained for debug.
         for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = 1'b0;
            ctrl_d[i]  = '0;
            if (CLEAR_DATA != 0) begin
               data_d[i] = '0;
            end
         end
         bubble_ev = 1'b1;
      end else if (flush || !freeze) begin
         // Older entries move on; a flush overrides freeze so they are not lost.
         for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            ctrl_d[i]  = ctrl_q[i-1];
            data_d[i]  = data_q[i-1];
         end

         if (flush) begin
            valid_d[0] = 1'b0;
            ctrl_d[0]  = '0;
            data_d[0]  = (CLEAR_DATA != 0) ? '0 : in_data;
            bubble_ev  = 1'b1;
         end else begin
            valid_d[0] = in_valid;
            ctrl_d[0]  = in_ctrl & {CTRL_W{in_valid}};
            data_d[0]  = in_data;
            bubble_ev  = !in_valid;
         end
      end
   end

   // Occupancy is taken from next-state valids so it lines up with tap_valid.
   always_comb begin
      occ_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ_d = occ_d + {3'b000, valid_d[i]};
      end
   end

   // Stage, occupancy and bubble counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ctrl_q[i] <= '0;
            data_q[i] <= '0;
         end
         occ_q <= '0;
         bub_q <= '0;
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < DEPTH; i++) begin
            ctrl_q[i] <= ctrl_d[i];
            data_q[i] <= data_d[i];
         end
         occ_q <= occ_d;
         if (bubble_ev && (bub_q != BUB_MAX)) begin
            bub_q <= bub_q + BUB_ONE;
         end
      end
   end

   // Every output comes straight from a register.
   assign out_valid  = valid_q[DEPTH-1];
   assign out_ctrl   = ctrl_q[DEPTH-1];
   assign out_data   = data_q[DEPTH-1];
   assign tap_valid  = valid_q;
   assign occupancy  = occ_q;
   assign bubble_cnt = bub_q;

endmodule

// File: tb/tb_pipe_stage_reg_chain.sv
// Bench for pipe_stage_reg_chain. Four instances share one input set:
//   u_d1: DEPTH=1 defaults
//   u_d2: DEPTH=2
//   u_d3: DEPTH=3, CLEAR_DATA=1
//   u_d4: DEPTH=4, CLEAR_DATA=0, BUB_CNT_W=4
// A per-edge reference model pushes expected outputs for every instance; a
// monitor pops and compares them after each edge. Scenario tasks add their
// own checks on values worked out by hand.

module tb_pipe_stage_reg_chain;

   // ---------------- clock / reset / inputs ----------------
   logic         clk = 1'b0;
   logic         rst;
   logic         freeze;
   logic         flush;
   logic         flush_all;
   logic         in_valid;
   logic [7:0]   in_ctrl;
   logic [127:0] in_data;

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------- DUT outputs ----------------
   logic         d1_valid, d2_valid, d3_valid, d4_valid;
   logic [7:0]   d1_ctrl, d2_ctrl, d3_ctrl, d4_ctrl;
   logic [127:0] d1_data, d2_data, d3_data, d4_data;
   logic [0:0]   d1_tap;
   logic [1:0]   d2_tap;
   logic [2:0]   d3_tap;
   logic [3:0]   d4_tap;
   logic [3:0]   d1_occ, d2_occ, d3_occ, d4_occ;
   logic [15:0]  d1_bub, d2_bub, d3_bub;
   logic [3:0]   d4_bub;

   pipe_stage_reg_chain #(.CTRL_W(8), .DATA_W(128), .DEPTH(1), .CLEAR_DATA(1), .BUB_CNT_W(16)) u_d1 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .flush_all(flush_all),
      .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(d1_valid), .out_ctrl(d1_ctrl), .out_data(d1_data),
      .tap_valid(d1_tap), .occupancy(d1_occ), .bubble_cnt(d1_bub));

   pipe_stage_reg_chain #(.CTRL_W(8), .DATA_W(128), .DEPTH(2), .CLEAR_DATA(1), .BUB_CNT_W(16)) u_d2 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .flush_all(flush_all),
      .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(d2_valid), .out_ctrl(d2_ctrl), .out_data(d2_data),
      .tap_valid(d2_tap), .occupancy(d2_occ), .bubble_cnt(d2_bub));

   pipe_stage_reg_chain #(.CTRL_W(8), .DATA_W(128), .DEPTH(3), .CLEAR_DATA(1), .BUB_CNT_W(16)) u_d3 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .flush_all(flush_all),
      .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(d3_valid), .out_ctrl(d3_ctrl), .out_data(d3_data),
      .tap_valid(d3_tap), .occupancy(d3_occ), .bubble_cnt(d3_bub));

   pipe_stage_reg_chain #(.CTRL_W(8), .DATA_W(128), .DEPTH(4), .CLEAR_DATA(0), .BUB_CNT_W(4)) u_d4 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .flush_all(flush_all),
      .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(d4_valid), .out_ctrl(d4_ctrl), .out_data(d4_data),
      .tap_valid(d4_tap), .occupancy(d4_occ), .bubble_cnt(d4_bub));

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic         v;
      logic [7:0]   c;
      logic [127:0] d;
      logic [7:0]   tap;
      logic [3:0]   occ;
      logic [15:0]  bub;
   } exp_t;

   exp_t exp_q[$];

   int           depth_t [4] = '{1, 2, 3, 4};
   int           cd_t    [4] = '{1, 1, 1, 0};
   int           bmax_t  [4] = '{65535, 65535, 65535, 15};
   bit           mv [4][8];
   logic [7:0]   mc [4][8];
   logic [127:0] md [4][8];
   int           mb [4];

   // Advance the model by one edge using the current inputs; push expectations.
   task automatic model_step();
      for (int k = 0; k < 4; k++) begin
         int   dep;
         bit   bub;
         exp_t e;
         dep = depth_t[k];
         bub = 1'b0;
         if (rst) begin
            for (int i = 0; i < 8; i++) begin
               mv[k][i] = 1'b0;
               mc[k][i] = 8'h00;
               md[k][i] = '0;
            end
            mb[k] = 0;
         end else if (flush_all) begin
            for (int i = 0; i < dep; i++) begin
               mv[k][i] = 1'b0;
               mc[k][i] = 8'h00;
               if (cd_t[k] == 1) md[k][i] = '0;
            end
            bub = 1'b1;
         end else if (flush || !freeze) begin
            for (int i = dep - 1; i >= 1; i--) begin
               mv[k][i] = mv[k][i-1];
               mc[k][i] = mc[k][i-1];
               md[k][i] = md[k][i-1];
            end
            if (flush) begin
               mv[k][0] = 1'b0;
               mc[k][0] = 8'h00;
               md[k][0] = (cd_t[k] == 1) ? 128'h0 : in_data;
               bub = 1'b1;
            end else begin
               mv[k][0] = in_valid;
               mc[k][0] = in_valid ? in_ctrl : 8'h00;
               md[k][0] = in_data;
               bub = !in_valid;
            end
         end
         if (bub && mb[k] < bmax_t[k]) mb[k] = mb[k] + 1;

         e.v   = mv[k][dep-1];
         e.c   = mc[k][dep-1];
         e.d   = md[k][dep-1];
         e.tap = '0;
         e.occ = '0;
         for (int i = 0; i < dep; i++) begin
            e.tap[i] = mv[k][i];
            if (mv[k][i]) e.occ = e.occ + 4'd1;
         end
         e.bub = 16'(mb[k]);
         exp_q.push_back(e);
      end
   endtask

   function automatic exp_t get_obs(input int k);
      exp_t o;
      case (k)
         0:       o = '{v: d1_valid, c: d1_ctrl, d: d1_data, tap: {7'b0, d1_tap}, occ: d1_occ, bub: d1_bub};
         1:       o = '{v: d2_valid, c: d2_ctrl, d: d2_data, tap: {6'b0, d2_tap}, occ: d2_occ, bub: d2_bub};
         2:       o = '{v: d3_valid, c: d3_ctrl, d: d3_data, tap: {5'b0, d3_tap}, occ: d3_occ, bub: d3_bub};
         default: o = '{v: d4_valid, c: d4_ctrl, d: d4_data, tap: {4'b0, d4_tap}, occ: d4_occ, bub: {12'b0, d4_bub}};
      endcase
      return o;
   endfunction

   // Scoreboard: after every edge, compare each instance against its expectation.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() >= 4) begin
         for (int k = 0; k < 4; k++) begin
            exp_t e;
            exp_t o;
            e = exp_q.pop_front();
            o = get_obs(k);
            checks++;
            if (o !== e) begin
               failures++;
               $display("FAIL sb_inst%0d t=%0t got v=%0b c=%h d=%h tap=%h occ=%0d bub=%0d exp v=%0b c=%h d=%h tap=%h occ=%0d bub=%0d",
                        k, $time, o.v, o.c, o.d, o.tap, o.occ, o.bub, e.v, e.c, e.d, e.tap, e.occ, e.bub);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      rst = 1'b0; freeze = 1'b0; flush = 1'b0; flush_all = 1'b0;
      in_valid = 1'b0; in_ctrl = 8'h00; in_data = '0;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #2;
   endtask

   task automatic reset_cycle();
      set_idle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      set_idle();
      rst = 1'b1; in_valid = 1'b1; in_ctrl = 8'hFF; in_data = {128{1'b1}};
      for (int n = 0; n < 2; n++) begin
         cycle();
         checks++;
         if ({d3_valid, d3_ctrl, d3_tap, d3_occ, d3_bub} !== 32'h0 || d3_data !== 128'h0) begin
            failures++;
            $display("FAIL reset_d3 got v=%0b c=%h tap=%b occ=%0d bub=%0d d=%h exp all zero",
                     d3_valid, d3_ctrl, d3_tap, d3_occ, d3_bub, d3_data);
         end
         checks++;
         if ({d4_valid, d4_ctrl, d4_tap, d4_occ, d4_bub} !== 21'h0 || d4_data !== 128'h0) begin
            failures++;
            $display("FAIL reset_d4 got v=%0b c=%h tap=%b occ=%0d bub=%0d exp all zero",
                     d4_valid, d4_ctrl, d4_tap, d4_occ, d4_bub);
         end
      end
      set_idle();
   endtask

   task automatic test_latency();
      logic [3:0] exp_ov;
      logic [3:0] exp_occ [4];
      exp_ov  = 4'b0100;   // bit e-1: out_valid after edge e
      exp_occ = '{4'd1, 4'd1, 4'd1, 4'd0};
      reset_cycle();
      for (int e = 1; e <= 4; e++) begin
         set_idle();
         if (e == 1) begin
            in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 128'h1234;
         end
         cycle();
         checks++;
         if (d3_valid !== exp_ov[e-1] || d3_occ !== exp_occ[e-1]) begin
            failures++;
            $display("FAIL latency_e%0d got v=%0b occ=%0d exp v=%0b occ=%0d",
                     e, d3_valid, d3_occ, exp_ov[e-1], exp_occ[e-1]);
         end
         if (e == 3) begin
            checks++;
            if (d3_ctrl !== 8'h5A || d3_data !== 128'h1234) begin
               failures++;
               $display("FAIL latency_payload got c=%h d=%h exp c=5a d=1234", d3_ctrl, d3_data);
            end
         end
      end
      checks++;
      if (d3_bub !== 16'd3) begin
         failures++;
         $display("FAIL latency_bubbles got %0d exp 3", d3_bub);
      end
   endtask

   task automatic test_freeze();
      reset_cycle();
      in_valid = 1'b1; in_ctrl = 8'h11; in_data = 128'hAAAA;
      cycle();
      in_ctrl = 8'h22; in_data = 128'hBBBB;
      cycle();
      freeze = 1'b1; in_ctrl = 8'h77; in_data = 128'h7777;
      for (int n = 0; n < 3; n++) begin
         cycle();
         checks++;
         if (d2_valid !== 1'b1 || d2_ctrl !== 8'h11 || d2_data !== 128'hAAAA ||
             d2_tap !== 2'b11 || d2_occ !== 4'd2 || d2_bub !== 16'd0) begin
            failures++;
            $display("FAIL freeze_hold%0d got v=%0b c=%h d=%h tap=%b occ=%0d bub=%0d exp v=1 c=11 d=aaaa tap=11 occ=2 bub=0",
                     n, d2_valid, d2_ctrl, d2_data, d2_tap, d2_occ, d2_bub);
         end
      end
      set_idle();
      cycle();
      checks++;
      if (d2_valid !== 1'b1 || d2_ctrl !== 8'h22 || d2_data !== 128'hBBBB || d2_tap !== 2'b10 || d2_occ !== 4'd1) begin
         failures++;
         $display("FAIL freeze_release got v=%0b c=%h d=%h tap=%b occ=%0d exp v=1 c=22 d=bbbb tap=10 occ=1",
                  d2_valid, d2_ctrl, d2_data, d2_tap, d2_occ);
      end
      cycle();
      checks++;
      if (d2_valid !== 1'b0 || d2_occ !== 4'd0) begin
         failures++;
         $display("FAIL freeze_drain got v=%0b occ=%0d exp v=0 occ=0", d2_valid, d2_occ);
      end
   endtask

   task automatic test_flush_beats_freeze();
      reset_cycle();
      in_valid = 1'b1; in_ctrl = 8'h33; in_data = 128'hCCCC;
      cycle();
      freeze = 1'b1; flush = 1'b1; in_ctrl = 8'hFF; in_data = 128'hDDDD;
      cycle();
      checks++;
      if (d4_tap !== 4'b0010 || d4_occ !== 4'd1 || d4_bub !== 4'd1) begin
         failures++;
         $display("FAIL flush_freeze_edge got tap=%b occ=%0d bub=%0d exp tap=0010 occ=1 bub=1",
                  d4_tap, d4_occ, d4_bub);
      end
      set_idle();
      cycle();
      cycle();
      checks++;
      if (d4_valid !== 1'b1 || d4_ctrl !== 8'h33 || d4_data !== 128'hCCCC) begin
         failures++;
         $display("FAIL flush_older_entry got v=%0b c=%h d=%h exp v=1 c=33 d=cccc", d4_valid, d4_ctrl, d4_data);
      end
      checks++;
      if (d3_valid !== 1'b0 || d3_ctrl !== 8'h00 || d3_data !== 128'h0) begin
         failures++;
         $display("FAIL flush_bubble_cleared got v=%0b c=%h d=%h exp v=0 c=00 d=0", d3_valid, d3_ctrl, d3_data);
      end
      cycle();
      checks++;
      if (d4_valid !== 1'b0 || d4_ctrl !== 8'h00 || d4_data !== 128'hDDDD || d4_bub !== 4'd4) begin
         failures++;
         $display("FAIL flush_bubble_keepdata got v=%0b c=%h d=%h bub=%0d exp v=0 c=00 d=dddd bub=4",
                  d4_valid, d4_ctrl, d4_data, d4_bub);
      end
   endtask

   task automatic test_flush_all();
      reset_cycle();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_ctrl = 8'h40 + 8'(i); in_data = 128'(i + 1);
         cycle();
      end
      checks++;
      if (d4_tap !== 4'b1111 || d4_occ !== 4'd4 || d4_ctrl !== 8'h40 || d4_data !== 128'h1) begin
         failures++;
         $display("FAIL flush_all_fill got tap=%b occ=%0d c=%h d=%h exp tap=1111 occ=4 c=40 d=1",
                  d4_tap, d4_occ, d4_ctrl, d4_data);
      end
      flush_all = 1'b1; in_valid = 1'b1; in_ctrl = 8'hEE;
      cycle();
      checks++;
      if (d4_tap !== 4'b0000 || d4_occ !== 4'd0 || d4_valid !== 1'b0 || d4_ctrl !== 8'h00 ||
          d4_data !== 128'h1 || d4_bub !== 4'd1) begin
         failures++;
         $display("FAIL flush_all_d4 got tap=%b occ=%0d v=%0b c=%h d=%h bub=%0d exp tap=0000 occ=0 v=0 c=00 d=1 bub=1",
                  d4_tap, d4_occ, d4_valid, d4_ctrl, d4_data, d4_bub);
      end
      checks++;
      if (d3_data !== 128'h0 || d3_occ !== 4'd0) begin
         failures++;
         $display("FAIL flush_all_d3 got d=%h occ=%0d exp d=0 occ=0", d3_data, d3_occ);
      end
      set_idle();
   endtask

   task automatic test_saturation();
      reset_cycle();
      for (int n = 1; n <= 20; n++) begin
         cycle();
         checks++;
         if (d4_bub !== 4'((n > 15) ? 15 : n)) begin
            failures++;
            $display("FAIL saturate_n%0d got %0d exp %0d", n, d4_bub, (n > 15) ? 15 : n);
         end
      end
      checks++;
      if (d3_bub !== 16'd20) begin
         failures++;
         $display("FAIL saturate_wide got %0d exp 20", d3_bub);
      end
   endtask

   task automatic test_reset_mid_stream();
      reset_cycle();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_ctrl = 8'h90 + 8'(i); in_data = 128'(i + 7);
         cycle();
      end
      rst = 1'b1;
      cycle();
      checks++;
      if (d4_tap !== 4'b0000 || d4_occ !== 4'd0 || d4_bub !== 4'd0 || d3_valid !== 1'b0 || d3_ctrl !== 8'h00) begin
         failures++;
         $display("FAIL reset_mid got tap=%b occ=%0d bub=%0d d3v=%0b d3c=%h exp all zero",
                  d4_tap, d4_occ, d4_bub, d3_valid, d3_ctrl);
      end
      set_idle();
   endtask

   task automatic test_back_to_back();
      reset_cycle();
      for (int n = 0; n < 400; n++) begin
         rst       = ($urandom_range(0, 59) == 0);
         flush_all = ($urandom_range(0, 19) == 0);
         flush     = ($urandom_range(0, 7) == 0);
         freeze    = ($urandom_range(0, 3) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_ctrl   = 8'($urandom_range(0, 255));
         in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
         cycle();
      end
      set_idle();
      cycle();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_drain got %0d pending exp 0", exp_q.size());
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      set_idle();
      test_reset();
      test_latency();
      test_freeze();
      test_flush_beats_freeze();
      test_flush_all();
      test_saturation();
      test_reset_mid_stream();
      test_back_to_back();
      @(posedge clk);
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
